// File: rtl/tube_pkg.sv
// Shared constants for the 8-digit multiplexed tube display: segment code
// table (active-low, dp off), blank code and digit count.
package tube_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;

    // Entry n is the active-low pattern for hex digit n; element 15 is listed first.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // One-cold anode pattern for a digit index.
    function automatic logic [7:0] digit_anode(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to 8-bit seven-segment decoder (active-low, dp off).
module hex7seg
    import tube_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/tube_scan.sv
// Multiplexed 8-digit hex tube driver with a byte-writable value register.
// Optional leading-zero blanking is enabled by defining TUBE_LZB_EN.
module tube_scan
    import tube_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic [7:0]  digit_sel,
    output logic [7:0]  seg
);

    localparam int unsigned      CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      value_q, value_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       digit_sel_q, digit_sel_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       nibble_s;
    logic [7:0]       hex_seg_s;
    logic             blank_s;

    // Byte-lane masked update of the display value.
    always_comb begin
        value_d = value_q;
        for (int i = 0; i < 4; i++) begin
            if (we && byteen[i]) begin
                value_d[8*i +: 8] = WD[8*i +: 8];
            end else begin
                value_d[8*i +: 8] = value_q[8*i +: 8];
            end
        end
    end

    // Dwell divider and digit index; writes never disturb the scan position.
    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            if (idx_q == 3'(NUM_DIGITS - 1)) begin
                idx_d = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            div_cnt_d = div_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign nibble_s = value_q[{idx_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (nibble_s),
        .seg    (hex_seg_s)
    );

`ifdef TUBE_LZB_EN
    logic [31:0] upper_s;
    assign upper_s = value_q >> {idx_q, 2'b00};

    // A digit is blank when it and everything above it is zero; digit 0 always shows.
    always_comb begin
        if (idx_q != 3'd0) begin
            blank_s = (upper_s == 32'd0);
        end else begin
            blank_s = 1'b0;
        end
    end
`else
    assign blank_s = 1'b0;
`endif

    // Next pin values, registered one cycle behind idx/value.
    always_comb begin
        digit_sel_d = digit_anode(idx_q);
        if (blank_s) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = hex_seg_s;
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q     <= 32'd0;
            div_cnt_q   <= '0;
            idx_q       <= 3'd0;
            digit_sel_q <= SEG_BLANK;
            seg_q       <= SEG_BLANK;
        end else begin
            value_q     <= value_d;
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign RD        = value_q;
    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_tube_scan.sv
// Randomized self-checking bench for tube_scan against a scan-time model,
// plus literal scan patterns for known register values.
module tb_tube_scan;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] WD;
    logic [31:0] RD;
    logic [7:0]  digit_sel;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    tube_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .byteen    (byteen),
        .WD        (WD),
        .RD        (RD),
        .digit_sel (digit_sel),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_code(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [31:0] v, input int k);
        logic [31:0] up;
        up = v >> (4 * k);
`ifdef TUBE_LZB_EN
        if (k > 0 && up == 32'd0) return 8'hFF;
`endif
        return hex_code(up[3:0]);
    endfunction

    // Model: value register, value shown after the latest edge, edges since reset.
    logic [31:0] m_val;
    logic [31:0] m_shown;
    int          m_edges;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_val   <= 32'd0;
            m_shown <= 32'd0;
            m_edges <= 0;
        end else begin
            logic [31:0] nv;
            nv = m_val;
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (byteen[i]) nv[8*i +: 8] = WD[8*i +: 8];
            end
            m_shown <= m_val;
            m_val   <= nv;
            m_edges <= m_edges + 1;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        int k;
        chk("rd", RD, m_val);
        if (!reset || m_edges == 0) begin
            chk("sel_idle", {24'd0, digit_sel}, 32'hFF);
            chk("seg_idle", {24'd0, seg}, 32'hFF);
        end else begin
            k = ((m_edges - 1) / SCAN_DIV) % 8;
            chk("sel", {24'd0, digit_sel}, {24'd0, ~(8'd1 << k)});
            chk("seg", {24'd0, seg}, {24'd0, exp_seg(m_shown, k)});
        end
    end

    task automatic wr(input logic [3:0] be, input logic [31:0] d);
        we = 1'b1; byteen = be; WD = d;
        @(negedge clk);
        we = 1'b0; byteen = 4'b0000; WD = $urandom;
    endtask

    task automatic wait_sel(input logic [7:0] target);
        for (int i = 0; i < 8 * SCAN_DIV + 4; i++) begin
            if (digit_sel == target) return;
            @(negedge clk);
        end
        chk("wait_sel_timeout", {24'd0, digit_sel}, {24'd0, target});
    endtask

    // Checks one full scan from digit 0; exp[8k+:8] is the pattern for digit k.
    task automatic check_scan(input string name, input logic [63:0] exp);
        wait_sel(8'hFD);
        wait_sel(8'hFE);
        for (int c = 0; c < 8 * SCAN_DIV; c++) begin
            chk({name, "_sel"}, {24'd0, digit_sel}, {24'd0, ~(8'd1 << (c / SCAN_DIV))});
            chk({name, "_seg"}, {24'd0, seg}, {24'd0, exp[8*(c / SCAN_DIV) +: 8]});
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; byteen = 4'b0000; WD = 32'd0;
        repeat (3) @(negedge clk);
        chk("lit_rst_sel", {24'd0, digit_sel}, 32'hFF);
        chk("lit_rst_seg", {24'd0, seg}, 32'hFF);
        reset = 1'b1;
        @(negedge clk);
        chk("lit_first_sel", {24'd0, digit_sel}, 32'hFE);
        chk("lit_first_seg", {24'd0, seg}, 32'hC0);

        wr(4'b1111, 32'h0AFD2403);
        chk("lit_rd_full", RD, 32'h0AFD2403);
`ifdef TUBE_LZB_EN
        check_scan("lit_scan1", 64'hFF888EA1A499C0B0);
`else
        check_scan("lit_scan1", 64'hC0888EA1A499C0B0);
`endif

        wr(4'b1100, 32'h054AF17B);
        chk("lit_rd_partial", RD, 32'h054A2403);
        wait_sel(8'hBF);
        chk("lit_digit6", {24'd0, seg}, 32'h92);

        wr(4'b0000, 32'hFFFFFFFF);
        chk("lit_rd_noop", RD, 32'h054A2403);

`ifdef TUBE_LZB_EN
        wr(4'b1111, 32'h00000030);
        check_scan("lit_lzb30", 64'hFFFFFFFFFFFFB0C0);
        wr(4'b1111, 32'h00000000);
        check_scan("lit_lzb0", 64'hFFFFFFFFFFFFFFC0);
        wr(4'b1111, 32'h054A2403);
`endif

        wait_sel(8'hDF);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("lit_async_sel", {24'd0, digit_sel}, 32'hFF);
        chk("lit_async_seg", {24'd0, seg}, 32'hFF);
        chk("lit_async_rd", RD, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("lit_restart_sel", {24'd0, digit_sel}, 32'hFE);
        chk("lit_restart_seg", {24'd0, seg}, 32'hC0);
        chk("lit_restart_rd", RD, 32'd0);

        for (int it = 0; it < 600; it++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                #($urandom_range(1, 4)) reset = 1'b0;
                #1;
                chk("rnd_async_sel", {24'd0, digit_sel}, 32'hFF);
                chk("rnd_async_seg", {24'd0, seg}, 32'hFF);
                @(negedge clk);
                reset = 1'b1;
            end else begin
                wr(4'($urandom_range(0, 15)), $urandom);
            end
        end
        repeat (8 * SCAN_DIV) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
